vga_timing_gen: RTL

- Parametrised successor to the fixed 800x600 sync generator; produces hsync, vsync, display enable and pixel coordinates for any VESA-style mode.
- Adds per-mode porch/sync parameters, selectable sync polarity, a pixel clock-enable so it can run from a faster system clock, and line/frame start strobes.
- Sits between the clock source and the pixel/framebuffer logic in the VGA module.
- Blanked coordinates are driven to 0, not high-impedance.

---
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator for VESA-style video modes. It produces
// horizontal/vertical sync, a display-enable window, active-area pixel
// coordinates, and line/frame start strobes. Timing advances only on clock
// edges where pix_en is high, so the block can run from a system clock that is
// faster than the pixel clock.
//
// Every output is registered from the current (h, v) position before that
// position advances. Outputs therefore lag the counters by one pixel tick, and
// no input has a combinational path to any output.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous reset, active-high; overrides pix_en
//   pix_en         in   pixel tick qualifier (tie high when clk is the pixel clock)
//   display_enable out  high while the emitted position is in the active area
//   hsync          out  horizontal sync; asserted level given by H_POL
//   vsync          out  vertical sync; asserted level given by V_POL
//   x_pos          out  active-area column, 0 while blanked
//   y_pos          out  active-area row, 0 while blanked
//   line_start     out  high for the pixel period of position (0, v)
//   frame_start    out  high for the pixel period of position (0, 0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_en,
    output logic           display_enable,
    output logic           hsync,
    output logic           vsync,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries sized to the counters. Every porch is at least one unit wide,
    // so each boundary below is strictly less than the total and fits the
    // counter width.
    localparam logic [X_W-1:0] H_LAST       = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_END    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SYNC_BEGIN = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SYNC_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST       = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SYNC_BEGIN = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    // Position counters
    logic [X_W-1:0] h_reg, h_next;
    logic [Y_W-1:0] v_reg, v_next;

    // Registered outputs
    logic           de_reg;
    logic           hsync_reg;
    logic           vsync_reg;
    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;
    logic           line_start_reg;
    logic           frame_start_reg;

    // Decode of the current position
    logic de_now;
    logic hsync_zone;
    logic vsync_zone;

    assign de_now     = (h_reg < H_ACT_END) && (v_reg < V_ACT_END);
    assign hsync_zone = (h_reg >= H_SYNC_BEGIN) && (h_reg < H_SYNC_END);
    // vsync covers whole lines, so it depends on v only.
    assign vsync_zone = (v_reg >= V_SYNC_BEGIN) && (v_reg < V_SYNC_END);

    // Raster advance: h runs 0..H_TOTAL-1, v steps when h wraps.
    always_comb begin
        h_next = h_reg + X_W'(1);
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            if (v_reg == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = v_reg + Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_reg           <= '0;
            v_reg           <= '0;
            de_reg          <= 1'b0;
            hsync_reg       <= ~H_POL;
            vsync_reg       <= ~V_POL;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (pix_en) begin
            // Outputs capture the position being left, then the counters move.
            de_reg          <= de_now;
            hsync_reg       <= hsync_zone ? H_POL : ~H_POL;
            vsync_reg       <= vsync_zone ? V_POL : ~V_POL;
            x_reg           <= de_now ? h_reg : '0;
            y_reg           <= de_now ? v_reg : '0;
            line_start_reg  <= (h_reg == '0);
            frame_start_reg <= (h_reg == '0) && (v_reg == '0);
            h_reg           <= h_next;
            v_reg           <= v_next;
        end
    end

    assign display_enable = de_reg;
    assign hsync          = hsync_reg;
    assign vsync          = vsync_reg;
    assign x_pos          = x_reg;
    assign y_pos          = y_reg;
    assign line_start     = line_start_reg;
    assign frame_start    = frame_start_reg;

    // Parameter sanity checks; simulation only, ignored by synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (H_FP >= 1 && H_SYNC >= 1 && H_BP >= 1)
                else $error("vga_timing_gen: horizontal porch/sync must be >= 1");
            assert (V_FP >= 1 && V_SYNC >= 1 && V_BP >= 1)
                else $error("vga_timing_gen: vertical porch/sync must be >= 1");
            assert (H_TOTAL <= (1 << X_W))
                else $error("vga_timing_gen: X_W too narrow for H_TOTAL");
            assert (V_TOTAL <= (1 << Y_W))
                else $error("vga_timing_gen: Y_W too narrow for V_TOTAL");
        end
    end

endmodule
